// File: rtl/ttl_bcd_scan_latch_pkg.sv
// Shared constants for the BCD scan latch: 7-segment patterns {g,f,e,d,c,b,a}
// and the BCD code driven for a suppressed leading zero.
package ttl_bcd_scan_latch_pkg;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_E     = 7'h79;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  localparam logic [3:0] BCD_SUPPRESSED = 4'b1111;

endpackage

// File: rtl/ttl_bcd_scan_latch_if.sv
// Bus between the counter/display world and the scan latch: capture controls,
// packed digits in, multiplexed BCD/segment/select out.
interface ttl_bcd_scan_latch_if #(
  parameter int DIGITS = 4,
  parameter int WIDTH  = 4
);

  logic                      Strobe;
  logic [DIGITS*WIDTH-1:0]   D;
  logic                      Carry;
  logic                      LZS;
  logic                      Blank_bar;
  logic [WIDTH-1:0]          BCD;
  logic [6:0]                Seg;
  logic [DIGITS-1:0]         Digit_sel;
  logic                      Overflow;

  modport master (
    output Strobe, D, Carry, LZS, Blank_bar,
    input  BCD, Seg, Digit_sel, Overflow
  );

  modport slave (
    input  Strobe, D, Carry, LZS, Blank_bar,
    output BCD, Seg, Digit_sel, Overflow
  );

endinterface

// File: rtl/ttl_bcd_scan_latch_seg7.sv
// Combinational BCD to 7-segment decoder; codes 10..15 show an "E".
module ttl_bcd_to_seg7
  import ttl_bcd_scan_latch_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_E;
    unique case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_E;
    endcase
  end

endmodule

// File: rtl/ttl_bcd_scan_latch.sv
// Strobed holding latch for cascaded BCD counters with a multiplexed display
// scanner and optional leading-zero suppression.
module ttl_bcd_scan_latch
  import ttl_bcd_scan_latch_pkg::*;
#(
  parameter int DIGITS     = 4,
  parameter int WIDTH      = 4,
  parameter int SCAN_DIV   = 4,
  parameter int DELAY_RISE = 0,
  parameter int DELAY_FALL = 0
) (
  input  logic                 Clk,
  input  logic                 Reset,
  ttl_bcd_scan_latch_if.slave  bus
);

  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  // Propagation delays belong to the board-level model; synthesized outputs
  // are zero-delay, so the parameters are accepted but shape no logic.
  if (DELAY_RISE != 0 || DELAY_FALL != 0) begin : g_nonzero_delay
  end

  logic [DIGITS*WIDTH-1:0] latch_p0;
  logic                    ovf_p0;
  logic [PRE_W-1:0]        pre_p0;
  logic [IDX_W-1:0]        idx_p0;

  // Bit k is set when digit k and every digit above it are zero; digit 0 is
  // always shown so a zero reading never goes fully dark.
  function automatic logic [DIGITS-1:0] lead_zero_mask(
    input logic [DIGITS*WIDTH-1:0] v
  );
    logic [DIGITS-1:0] m;
    logic              run;
    m   = '0;
    run = 1'b1;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      run  = run && (v[k*WIDTH +: WIDTH] == '0);
      m[k] = run;
    end
    return m;
  endfunction

  // Stage p0: capture latch and scan counters
  always_ff @(posedge Clk) begin
    if (Reset) begin
      latch_p0 <= '0;
      ovf_p0   <= 1'b0;
      pre_p0   <= '0;
      idx_p0   <= '0;
    end else begin
      if (pre_p0 == PRE_W'(SCAN_DIV - 1)) begin
        pre_p0 <= '0;
        idx_p0 <= (idx_p0 == IDX_W'(DIGITS - 1)) ? '0 : idx_p0 + 1'b1;
      end else begin
        pre_p0 <= pre_p0 + 1'b1;
      end
      if (bus.Strobe) begin
        latch_p0 <= bus.D;
        ovf_p0   <= bus.Carry;
      end
    end
  end

  // Output decode straight from the p0 registers
  logic [WIDTH-1:0]  digit;
  logic [6:0]        seg_raw;
  logic [DIGITS-1:0] zmask;
  logic              suppressed;

  assign digit      = latch_p0[idx_p0*WIDTH +: WIDTH];
  assign zmask      = lead_zero_mask(latch_p0);
  assign suppressed = bus.LZS && zmask[idx_p0];

  ttl_bcd_to_seg7 u_seg7 (
    .bcd (digit),
    .seg (seg_raw)
  );

  assign bus.BCD       = suppressed ? BCD_SUPPRESSED : digit;
  assign bus.Seg       = suppressed ? SEG_BLANK : seg_raw;
  assign bus.Digit_sel = bus.Blank_bar ? (DIGITS'(1) << idx_p0) : '0;
  assign bus.Overflow  = ovf_p0;

endmodule

// File: tb/tb_ttl_bcd_scan_latch.sv
// Randomized and directed bench for ttl_bcd_scan_latch against a cycle-count
// based reference model (DIGITS=4, SCAN_DIV=2).
module tb_ttl_bcd_scan_latch;

  localparam int DIGITS   = 4;
  localparam int WIDTH    = 4;
  localparam int SCAN_DIV = 2;

  logic Clk;
  logic Reset;

  ttl_bcd_scan_latch_if #(.DIGITS(DIGITS), .WIDTH(WIDTH)) bus();

  ttl_bcd_scan_latch #(
    .DIGITS     (DIGITS),
    .WIDTH      (WIDTH),
    .SCAN_DIV   (SCAN_DIV),
    .DELAY_RISE (0),
    .DELAY_FALL (0)
  ) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference state: edges since reset, latched word and overflow.
  int          ticks   = 0;
  logic [15:0] m_latch = '0;
  logic        m_ovf   = 1'b0;

  logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h79, 7'h79, 7'h79, 7'h79, 7'h79, 7'h79};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step(input logic rst_i, input logic strobe_i, input logic [15:0] d_i,
                      input logic carry_i, input logic lzs_i, input logic blank_i);
    int   idx;
    int   nib;
    logic sup;
    Reset         = rst_i;
    bus.Strobe    = strobe_i;
    bus.D         = d_i;
    bus.Carry     = carry_i;
    bus.LZS       = lzs_i;
    bus.Blank_bar = blank_i;
    @(posedge Clk);
    if (rst_i) begin
      ticks   = 0;
      m_latch = '0;
      m_ovf   = 1'b0;
    end else begin
      ticks++;
      if (strobe_i) begin
        m_latch = d_i;
        m_ovf   = carry_i;
      end
    end
    @(negedge Clk);
    idx = (ticks / SCAN_DIV) % DIGITS;
    nib = (m_latch >> (4 * idx)) & 15;
    sup = lzs_i && (idx > 0) && ((m_latch >> (4 * idx)) == 0);
    check("bcd",       32'(bus.BCD),       sup ? 32'hF : 32'(nib));
    check("seg",       32'(bus.Seg),       sup ? 32'h0 : 32'(seg_tab[nib]));
    check("digit_sel", 32'(bus.Digit_sel), blank_i ? (32'd1 << idx) : 32'd0);
    check("overflow",  32'(bus.Overflow),  32'(m_ovf));
  endtask

  task automatic idle(input int n, input logic [15:0] d_i, input logic lzs_i, input logic blank_i);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, d_i, 1'b0, lzs_i, blank_i);
  endtask

  initial begin
    logic [15:0] d;
    // Reset and free scan
    step(1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
    idle(10, 16'h0, 1'b0, 1'b1);
    // Capture 1234 with carry, then inputs change without strobe
    step(1'b0, 1'b1, 16'h1234, 1'b1, 1'b0, 1'b1);
    idle(9, 16'h9999, 1'b0, 1'b1);
    // Leading-zero suppression
    step(1'b0, 1'b1, 16'h0070, 1'b0, 1'b1, 1'b1);
    idle(8, 16'h0070, 1'b1, 1'b1);
    step(1'b0, 1'b1, 16'h0000, 1'b0, 1'b1, 1'b1);
    idle(8, 16'h0000, 1'b1, 1'b1);
    // Invalid nibble
    step(1'b0, 1'b1, 16'h00A5, 1'b0, 1'b0, 1'b1);
    idle(8, 16'h00A5, 1'b0, 1'b1);
    idle(8, 16'h00A5, 1'b1, 1'b1);
    // Blanking keeps the scan running
    idle(5, 16'h00A5, 1'b0, 1'b0);
    idle(6, 16'h00A5, 1'b0, 1'b1);
    // Reset beats strobe; strobe mid-scan leaves the schedule alone
    step(1'b1, 1'b1, 16'h5555, 1'b1, 1'b0, 1'b1);
    idle(4, 16'h5555, 1'b0, 1'b1);
    step(1'b0, 1'b1, 16'h5555, 1'b1, 1'b0, 1'b1);
    idle(6, 16'h5555, 1'b0, 1'b1);
    // Held strobe recaptures every edge
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 16'(i * 16'h1111), 1'(i), 1'b0, 1'b1);
    // Random traffic
    for (int i = 0; i < 600; i++) begin
      d = 16'($urandom);
      case ($urandom_range(0, 3))
        0: d = d & 16'h00FF;
        1: d = d & 16'h000F;
        2: d = d & 16'h0F0F;
        default: ;
      endcase
      step($urandom_range(0, 49) == 0, $urandom_range(0, 3) == 0, d,
           1'($urandom), 1'($urandom), $urandom_range(0, 7) != 0);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
